renode_interrupt_arbiter: RTL



---
 rtl/renode_interrupt_arbiter_if.sv | 19 +
 rtl/renode_interrupt_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/renode_interrupt_arbiter_if.sv
// rtl/renode_interrupt_arbiter_if.sv - interrupt message channel between the arbiter and the Renode sender
//
// Purpose: carries one (line index, level) interrupt message over a valid/ready handshake.
// Signals:
//   msg_valid  master -> slave  message available
//   msg_ready  slave -> master  sender accepts the message
//   msg_addr   master -> slave  interrupt line index
//   msg_level  master -> slave  reported level of that line
interface renode_interrupt_arbiter_if #(
   parameter int AddrWidth = 3
);
   logic                 msg_valid;
   logic                 msg_ready;
   logic [AddrWidth-1:0] msg_addr;
   logic                 msg_level;

   modport master (output msg_valid, output msg_addr, output msg_level, input msg_ready);
   modport slave  (input msg_valid, input msg_addr, input msg_level, output msg_ready);
endinterface

// File: rtl/renode_interrupt_arbiter.sv
// rtl/renode_interrupt_arbiter.sv - change-detecting round-robin arbiter of interrupt lines onto one message channel
//
// Purpose: remembers the last level reported for every interrupt line, flags a line pending when
// its input differs, and grants pending lines round-robin, one message in flight at a time.
// Ports:
//   clk              clock, all state updates on posedge
//   rst              asynchronous active-high reset; drops any in-flight message
//   interrupts       interrupt levels, synchronous to clk
//   enable           per-line enable; a disabled line silently tracks its input
//   hold             1 = issue no new grants (an already-valid message is unaffected)
//   msg              message channel (master side): msg_valid/msg_ready/msg_addr/msg_level
//   busy             1 while a message is outstanding (state SEND)
//   coalesced_count  saturating count of changes that reverted before being sent
module renode_interrupt_arbiter #(
   parameter int InterruptsCount = 8,
   parameter int AddrWidth       = (InterruptsCount > 1) ? $clog2(InterruptsCount) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [InterruptsCount-1:0] interrupts,
   input  logic [InterruptsCount-1:0] enable,
   input  logic                       hold,
   renode_interrupt_arbiter_if.master msg,
   output logic                       busy,
   output logic [15:0]                coalesced_count
);

   localparam int N = InterruptsCount;

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         reported_q, reported_d;
   logic [N-1:0]         pending_q, pending;
   logic [N-1:0]         sent_mask, cand, reverted;
   logic [AddrWidth-1:0] rr_q, rr_d, addr_q, addr_d, grant_idx;
   logic                 valid_q, valid_d, level_q, level_d;
   logic                 fire, found;
   logic [16:0]          coalesce_sum;

   assign fire    = (state_q == SEND) & valid_q & msg.msg_ready;
   assign pending = enable & (interrupts ^ reported_q);

   // One-hot of the line whose message completes this cycle.
   always_comb begin
      sent_mask = '0;
      if (fire) sent_mask[addr_q] = 1'b1;
   end

   // The line being handshaken is never re-granted on the same edge.
   assign cand = pending & ~sent_mask;

   // Round-robin search starting at rr_q, wrapping modulo N.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = int'(rr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!found && cand[idx]) begin
            found     = 1'b1;
            grant_idx = AddrWidth'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      level_d = level_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (!hold && found) begin
               state_d = SEND;
               valid_d = 1'b1;
               addr_d  = grant_idx;
               level_d = interrupts[grant_idx];
               rr_d    = (grant_idx == AddrWidth'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
         end
         SEND: begin
            if (fire) begin
               if (!hold && found) begin
                  valid_d = 1'b1;
                  addr_d  = grant_idx;
                  level_d = interrupts[grant_idx];
                  rr_d    = (grant_idx == AddrWidth'(N - 1)) ? '0 : grant_idx + 1'b1;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sent line takes the level that went out; disabled lines shadow their input so that
   // re-enabling never reports a stale change.
   always_comb begin
      reported_d = (reported_q & ~sent_mask) | (sent_mask & {N{level_q}});
      reported_d = (reported_d & enable) | (interrupts & ~enable);
   end

   // A line that was pending and is no longer, without having been sent, reverted unsent.
   assign reverted     = pending_q & ~pending & enable & ~sent_mask;
   assign coalesce_sum = {1'b0, coalesced_count} + 17'($countones(reverted));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         valid_q         <= 1'b0;
         addr_q          <= '0;
         level_q         <= 1'b0;
         rr_q            <= '0;
         reported_q      <= '0;
         pending_q       <= '0;
         coalesced_count <= '0;
      end else begin
         state_q         <= state_d;
         valid_q         <= valid_d;
         addr_q          <= addr_d;
         level_q         <= level_d;
         rr_q            <= rr_d;
         reported_q      <= reported_d;
         // The handshaken line is resolved by the send, so it must not later look like a revert.
         pending_q       <= pending & ~sent_mask;
         coalesced_count <= coalesce_sum[16] ? 16'hFFFF : coalesce_sum[15:0];
      end
   end

   assign msg.msg_valid = valid_q;
   assign msg.msg_addr  = addr_q;
   assign msg.msg_level = level_q;
   assign busy          = (state_q == SEND);

endmodule
